// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   state_e          : arbiter FSM states
//   GntIf / GntD     : encoding of the grant owner (gnt_d output)
//   LatDefault       : default memory access latency in cycles
//   StarveMaxDefault : default data-grant budget while fetch waits
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam logic GntIf = 1'b0;
  localparam logic GntD  = 1'b1;

  localparam int unsigned LatDefault       = 2;
  localparam int unsigned StarveMaxDefault = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Priority select between fetch and data requests with a starvation guard.
//   clk, rst_n  : clock, asynchronous active-low reset
//   arb_en      : arbitration window (FSM in IDLE); counter only moves here
//   if_req      : fetch request
//   d_req       : data request
//   grant_valid : a grant is made this cycle (combinational)
//   grant_d     : winner, 1=data 0=fetch (combinational, qualified by grant_valid)
module mem_arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic grant_valid,
  output logic grant_d
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          starved;

  assign starved = (starve_q == SW'(STARVE_MAX));

  // Data wins unless fetch has been passed over STARVE_MAX times in a row.
  always_comb begin
    grant_valid = arb_en & (if_req | d_req);
    grant_d     = d_req & ~(if_req & starved);
  end

  always_comb begin
    starve_d = starve_q;
    if (arb_en) begin
      if (!if_req) begin
        starve_d = '0;
      end else if (grant_d) begin
        if (!starved) starve_d = starve_q + SW'(1);
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch and data ports.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   if_req/if_addr             : fetch request (held until if_ack) and address
//   if_rdata/if_ack            : fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  : data request (held until d_ack), write flag, address, data
//   d_rdata/d_ack              : read data and one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory macro interface
//   busy                       : FSM not in IDLE
//   gnt_d                      : current/last grant owner, 1=data 0=fetch
// All outputs are registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LAT        = LatDefault,
  parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_d
);

  localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic              gnt_d_q, gnt_d_d;

  logic arb_en;
  logic grant_valid;
  logic grant_d;

  assign arb_en = (state_q == StIdle);

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk         (clk),
    .rst_n       (rst_n),
    .arb_en      (arb_en),
    .if_req      (if_req),
    .d_req       (d_req),
    .grant_valid (grant_valid),
    .grant_d     (grant_d)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    gnt_d_d    = gnt_d_q;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          gnt_d_d  = grant_d ? GntD : GntIf;
          addr_d   = grant_d ? d_addr : if_addr;
          we_d     = grant_d & d_we;
          if (grant_d && d_we) wdata_d = d_wdata;
          cnt_d    = CntW'(LAT - 1);
          mem_en_d = 1'b1;
          mem_we_d = grant_d & d_we;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          // Last access cycle: mem_rdata is valid now.
          if (gnt_d_q == GntD) begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
          state_d = StDone;
        end else begin
          cnt_d    = cnt_q - CntW'(1);
          mem_en_d = 1'b1;
          mem_we_d = we_q;
        end
      end
      StDone: begin
        // No arbitration here: the requester's req still refers to this access.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
      gnt_d_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      busy_q     <= busy_d;
      gnt_d_q    <= gnt_d_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign busy      = busy_q;
  assign gnt_d     = gnt_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (LAT=2, STARVE_MAX=2).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        gnt_d;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .LAT        (2),
    .STARVE_MAX (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .gnt_d     (gnt_d)
  );

  always #5 clk = ~clk;

  // Small memory model, word indexed by addr[7:2].
  logic [31:0] mem [64];
  assign mem_rdata = mem_en ? mem[mem_addr[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack is matched against the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (if_ack && d_ack) begin
      checks++;
      failures++;
      $display("FAIL ack_excl: if_ack and d_ack both high at %0t", $time);
    end else if (if_ack || d_ack) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL spurious_ack: got if_ack=%0b d_ack=%0b expected none at %0t",
                 if_ack, d_ack, $time);
      end else begin
        e = sb.pop_front();
        if (e.is_d !== d_ack || (d_ack ? d_rdata : if_rdata) !== e.data) begin
          failures++;
          $display("FAIL sb_ack: got port_d=%0b data=0x%08h expected port_d=%0b data=0x%08h at %0t",
                   d_ack, d_ack ? d_rdata : if_rdata, e.is_d, e.data, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h04] = 32'h8C020004; // 0x10
    mem[6'h05] = 32'h55667788; // 0x14
    mem[6'h08] = 32'hCAFEF00D; // 0x20
    mem[6'h10] = 32'h11223344; // 0x40
    mem[6'h20] = 32'h99999999; // 0x80
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #1;
    chk("rst_outs", {31'h0, mem_en | mem_we | busy | if_ack | d_ack | gnt_d}, 32'h0);
    chk("rst_rdata", if_rdata | d_rdata | mem_addr, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single fetch read.
    if_req = 1'b1; if_addr = 32'h10; push(1'b0, 32'h8C020004);
    tick(); // cycle 1
    chk("f_en_c1", {31'h0, mem_en}, 32'h1);
    chk("f_addr_c1", mem_addr, 32'h10);
    chk("f_gnt_c1", {31'h0, gnt_d}, 32'h0);
    tick(); // cycle 2
    chk("f_en_c2", {31'h0, mem_en}, 32'h1);
    tick(); // cycle 3
    chk("f_ack_c3", {30'h0, mem_en, if_ack}, 32'h1);
    chk("f_rdata_c3", if_rdata, 32'h8C020004);
    if_req = 1'b0;
    tick(); // cycle 4
    chk("f_busy_c4", {30'h0, busy, if_ack}, 32'h0);

    // Simultaneous requests: data first.
    if_req = 1'b1; if_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    push(1'b1, 32'h11223344); push(1'b0, 32'h55667788);
    tick(); // 1
    chk("s_gnt_c1", {31'h0, gnt_d}, 32'h1);
    chk("s_addr_c1", mem_addr, 32'h40);
    tick(); tick(); // 3
    chk("s_dack_c3", {31'h0, d_ack}, 32'h1);
    d_req = 1'b0;
    tick(); // 4
    chk("s_en_c4", {31'h0, mem_en}, 32'h0);
    tick(); // 5
    chk("s_fen_c5", {mem_en, gnt_d, 30'h0}, 32'h80000000);
    chk("s_faddr_c5", mem_addr, 32'h14);
    tick(); // 6
    chk("s_fen_c6", {31'h0, mem_en}, 32'h1);
    tick(); // 7
    chk("s_iack_c7", {31'h0, if_ack}, 32'h1);
    if_req = 1'b0;
    tick();

    // Data write: d_rdata keeps the previous read value.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hDEADBEEF;
    push(1'b1, 32'h11223344);
    tick(); // 1
    chk("w_enwe_c1", {30'h0, mem_en, mem_we}, 32'h3);
    chk("w_wdata_c1", mem_wdata, 32'hDEADBEEF);
    chk("w_addr_c1", mem_addr, 32'h44);
    tick(); // 2
    chk("w_enwe_c2", {30'h0, mem_en, mem_we}, 32'h3);
    tick(); // 3
    chk("w_ack_c3", {30'h0, mem_we, d_ack}, 32'h1);
    chk("w_rdata_c3", d_rdata, 32'h11223344);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    // Read back the written word.
    d_req = 1'b1; d_addr = 32'h44; push(1'b1, 32'hDEADBEEF);
    tick(); tick(); tick();
    chk("rb_ack_c3", {31'h0, d_ack}, 32'h1);
    d_req = 1'b0;
    tick();

    // Starvation guard: D, D, IF, D, D, IF.
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    push(1'b1, 32'h11223344); push(1'b1, 32'h11223344); push(1'b0, 32'h8C020004);
    push(1'b1, 32'h11223344); push(1'b1, 32'h11223344); push(1'b0, 32'h8C020004);
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      tick();
      if (if_ack || d_ack) n++;
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("starve_acks", n, 6);
    tick();

    // Reset during the second ACCESS cycle: aborted, never acked.
    d_req = 1'b1; d_addr = 32'h40;
    tick(); tick(); // cycle 2
    rst_n = 1'b0;
    #1;
    chk("r_outs", {28'h0, mem_en, busy, if_ack, d_ack}, 32'h0);
    chk("r_rdata", d_rdata | if_rdata, 32'h0);
    d_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 32'h20; push(1'b0, 32'hCAFEF00D);
    tick(); tick();
    chk("r_noack_c2", {31'h0, if_ack}, 32'h0);
    tick(); // 3
    chk("r_iack_c3", {31'h0, if_ack}, 32'h1);
    if_req = 1'b0;
    tick();

    // Address change during ACCESS is ignored.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; push(1'b1, 32'h11223344);
    tick(); // 1
    chk("a_addr_c1", mem_addr, 32'h40);
    d_addr = 32'h80;
    tick(); // 2
    chk("a_addr_c2", mem_addr, 32'h40);
    tick(); // 3
    chk("a_ack_c3", {31'h0, d_ack}, 32'h1);
    d_req = 1'b0;
    tick(); tick(); tick();

    chk("sb_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
